// File: rtl/vga_line_fetcher_if.sv
// ----------------------------------------------------------------------------
// vga_line_fetcher_if
//   Paged memory read/write bus shared between an initiator (the line fetcher)
//   and a memory target.
//
//   Address  A bits  memory address of the current request (initiator drives)
//   PageMux  P bits  memory page of the current request    (initiator drives)
//   Read     1 bit   one-cycle read strobe                 (initiator drives)
//   Write    1 bit   write strobe                          (initiator drives)
//   MemData  8 bits  memory read data                      (target drives)
//
//   modport master : initiator side
//   modport slave  : memory side
// ----------------------------------------------------------------------------
interface vga_line_fetcher_if #(
    parameter int A = 18,
    parameter int P = 1
);
    logic [A-1:0] Address;
    logic [P-1:0] PageMux;
    logic         Read;
    logic         Write;
    logic [7:0]   MemData;

    modport master (
        output Address,
        output PageMux,
        output Read,
        output Write,
        input  MemData
    );

    modport slave (
        input  Address,
        input  PageMux,
        input  Read,
        input  Write,
        output MemData
    );
endinterface

// File: rtl/vga_line_fetcher.sv
// ----------------------------------------------------------------------------
// vga_line_fetcher
//   Read-side initiator for the paged memory bus. On each LineStart it walks
//   LineBytes consecutive {PageMux,Address} locations, issuing one read at a
//   time, and captures each returned byte ReadLatency cycles after its Read
//   strobe into a show-ahead FIFO. The pixel pipeline pops bytes at its own
//   pace.
//
//   Clk        in   system clock, rising edge
//   Reset      in   asynchronous, active-high reset
//   LineStart  in   1-cycle pulse: start (or restart) a line fetch
//   LineBase   in   A-bit start address, sampled on LineStart
//   LinePage   in   P-bit start page, sampled on LineStart
//   mem        if   memory bus, master side (Address/PageMux/Read/Write/MemData)
//   PixelPop   in   consumer takes PixelData this cycle
//   PixelData  out  FIFO head byte
//   PixelValid out  FIFO non-empty
//   Busy       out  line fetch in progress
//   Underflow  out  sticky: PixelPop seen while PixelValid was low
// ----------------------------------------------------------------------------
module vga_line_fetcher #(
    parameter int A           = 18,
    parameter int P           = 1,
    parameter int LineBytes   = 320,
    parameter int ReadLatency = 2,
    parameter int FifoDepth   = 16
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   LineStart,
    input  logic [A-1:0]           LineBase,
    input  logic [P-1:0]           LinePage,
    vga_line_fetcher_if.master     mem,
    input  logic                   PixelPop,
    output logic [7:0]             PixelData,
    output logic                   PixelValid,
    output logic                   Busy,
    output logic                   Underflow
);
    localparam int PW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int LW = (ReadLatency > 1) ? $clog2(ReadLatency) : 1;

    localparam logic [PW:0]   FULL_CNT   = (PW+1)'(FifoDepth);
    localparam logic [LW-1:0] LAST_WAIT  = LW'(ReadLatency - 1);
    localparam logic [15:0]   LINE_BYTES = 16'(LineBytes);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    logic [1:0]     state;
    logic [A+P-1:0] addr_q;      // {page, address} of the next read
    logic [15:0]    remaining;
    logic [LW-1:0]  wait_cnt;

    logic [7:0]     fifo_mem [FifoDepth];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [PW:0]    count;
    logic           underflow_q;

    logic has_space;
    logic read_en;
    logic capture;
    logic flush;
    logic do_push;
    logic do_pop;

    // Only one read is ever in flight, so space for one more entry at issue
    // time guarantees the capture can never overflow the FIFO.
    assign has_space = (count < FULL_CNT);
    assign read_en   = (state == ISSUE) && has_space;
    assign capture   = (state == WAIT) && (wait_cnt == LAST_WAIT);

    // A LineStart during a fetch aborts it: the FIFO is emptied and the byte
    // still in flight is dropped instead of pushed.
    assign flush     = LineStart && (state != IDLE);
    assign do_push   = capture && !LineStart;
    assign do_pop    = PixelPop && (count != '0) && !flush;

    // Fetch sequencing
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            remaining <= '0;
            wait_cnt  <= '0;
        end else if (LineStart) begin
            state     <= ISSUE;
            addr_q    <= {LinePage, LineBase};
            remaining <= LINE_BYTES;
            wait_cnt  <= '0;
        end else begin
            case (state)
                ISSUE: begin
                    if (has_space) begin
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (capture) begin
                        // Carry out of Address ripples into PageMux; the
                        // combined value wraps from all-ones to zero.
                        addr_q    <= addr_q + (A+P)'(1);
                        remaining <= remaining - 16'd1;
                        state     <= (remaining == 16'd1) ? IDLE : ISSUE;
                    end else begin
                        wait_cnt <= wait_cnt + LW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Show-ahead FIFO and underflow flag
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            underflow_q <= 1'b0;
            for (int i = 0; i < FifoDepth; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) begin
                    fifo_mem[wr_ptr] <= mem.MemData;
                    wr_ptr           <= wr_ptr + PW'(1);
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                case ({do_push, do_pop})
                    2'b10:   count <= count + (PW+1)'(1);
                    2'b01:   count <= count - (PW+1)'(1);
                    default: count <= count;
                endcase
            end

            if (LineStart) begin
                underflow_q <= 1'b0;
            end else if (PixelPop && (count == '0)) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign mem.Address = addr_q[A-1:0];
    assign mem.PageMux = addr_q[A+P-1:A];
    assign mem.Read    = read_en;
    assign mem.Write   = 1'b0;

    // With an empty FIFO the head slot is stale and simply holds its value.
    assign PixelData   = fifo_mem[rd_ptr];
    assign PixelValid  = (count != '0);
    assign Busy        = (state != IDLE);
    assign Underflow   = underflow_q;
endmodule

// File: tb/tb_vga_line_fetcher.sv
// ----------------------------------------------------------------------------
// tb_vga_line_fetcher
//   Three fetcher instances (LineBytes 4, 20 and 2) share clock and reset.
//   Each has its own memory model and a queue-based reference model that is
//   compared with the outputs on every falling clock edge. Directed sequences
//   pin the reference with literal values, then random traffic runs on all
//   instances at once.
// ----------------------------------------------------------------------------
module tb_vga_line_fetcher;
    localparam int A  = 18;
    localparam int P  = 1;
    localparam int RL = 2;
    localparam int FD = 16;
    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         ls    [NI];
    logic [A-1:0] lbase [NI];
    logic [P-1:0] lpage [NI];
    logic         pop   [NI];
    logic [7:0]   key   [NI];

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Memory contents: low address byte, perturbed by a per-instance key and
    // the top two bits of {page,address}.
    function automatic logic [7:0] memfn(input logic [7:0] k, input logic [A+P-1:0] a);
        return a[7:0] ^ k ^ {6'b0, a[A+P-1:A+P-2]};
    endfunction

    for (genvar g = 0; g < NI; g++) begin : inst
        localparam int LBG = (g == 0) ? 4 : (g == 1) ? 20 : 2;

        vga_line_fetcher_if #(.A(A), .P(P)) bus ();
        logic [7:0] pdata;
        logic       pvalid;
        logic       busy;
        logic       uflow;

        vga_line_fetcher #(
            .A(A), .P(P), .LineBytes(LBG), .ReadLatency(RL), .FifoDepth(FD)
        ) dut (
            .Clk(clk),
            .Reset(rst),
            .LineStart(ls[g]),
            .LineBase(lbase[g]),
            .LinePage(lpage[g]),
            .mem(bus),
            .PixelPop(pop[g]),
            .PixelData(pdata),
            .PixelValid(pvalid),
            .Busy(busy),
            .Underflow(uflow)
        );

        // Memory: data for a read seen at an edge appears RL cycles later;
        // garbage otherwise, so mistimed captures show up.
        logic [7:0] lat [RL];
        assign bus.MemData = lat[RL-1];
        always @(posedge clk) begin
            lat[0] <= bus.Read ? memfn(key[g], {bus.PageMux, bus.Address}) : 8'($urandom);
            for (int i = 1; i < RL; i++) lat[i] <= lat[i-1];
        end

        // Reference model: a line is a run of consecutive addresses; a read
        // issued in cycle c delivers its byte at the end of cycle c+RL.
        logic [7:0]     mq [$];
        logic           m_busy = 1'b0;
        logic           m_infl = 1'b0;
        logic           m_uf   = 1'b0;
        logic [A+P-1:0] m_next = '0;
        int             m_todo = 0;
        int             m_issue = 0;
        int             cyc = 0;
        logic           exp_read;

        initial forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                mq.delete();
                m_busy = 1'b0; m_infl = 1'b0; m_uf = 1'b0; m_next = '0; m_todo = 0;
            end
            exp_read = m_busy && !m_infl && (mq.size() < FD);
            check($sformatf("i%0d read", g), 32'(bus.Read), 32'(exp_read));
            check($sformatf("i%0d addr", g), 32'({bus.PageMux, bus.Address}), 32'(m_next));
            check($sformatf("i%0d write", g), 32'(bus.Write), 32'(0));
            check($sformatf("i%0d valid", g), 32'(pvalid), 32'(mq.size() != 0));
            if (mq.size() != 0) check($sformatf("i%0d data", g), 32'(pdata), 32'(mq[0]));
            check($sformatf("i%0d busy", g), 32'(busy), 32'(m_busy));
            check($sformatf("i%0d uflow", g), 32'(uflow), 32'(m_uf));
            if (!rst) begin
                if (ls[g]) begin
                    if (m_busy) mq.delete();
                    m_busy = 1'b1; m_infl = 1'b0; m_uf = 1'b0;
                    m_todo = LBG;
                    m_next = {lpage[g], lbase[g]};
                end else begin
                    if (pop[g]) begin
                        if (mq.size() != 0) void'(mq.pop_front());
                        else m_uf = 1'b1;
                    end
                    if (m_infl && (cyc == m_issue + RL)) begin
                        mq.push_back(memfn(key[g], m_next));
                        m_next = m_next + (A+P)'(1);
                        m_todo--;
                        m_infl = 1'b0;
                        if (m_todo == 0) m_busy = 1'b0;
                    end else if (exp_read) begin
                        m_infl  = 1'b1;
                        m_issue = cyc;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int         nrd;
    int         got;
    int         popprob;
    logic [7:0] hold;

    initial begin
        for (int i = 0; i < NI; i++) begin
            ls[i] = 1'b0; pop[i] = 1'b0; lbase[i] = '0; lpage[i] = '0;
        end
        key[0] = 8'h00;
        key[1] = 8'($urandom);
        key[2] = 8'($urandom);

        repeat (3) @(posedge clk);
        #1;
        check("reset addr",   32'(inst[0].bus.Address), 32'(0));
        check("reset page",   32'(inst[0].bus.PageMux), 32'(0));
        check("reset read",   32'(inst[0].bus.Read),    32'(0));
        check("reset pdata",  32'(inst[0].pdata),       32'(0));
        check("reset pvalid", 32'(inst[0].pvalid),      32'(0));
        check("reset busy",   32'(inst[0].busy),        32'(0));
        check("reset uflow",  32'(inst[0].uflow),       32'(0));
        rst = 1'b0;
        step();

        // Four-byte line at 0x100: reads in order, bytes 00..03.
        ls[0] = 1'b1; lbase[0] = 18'h00100; lpage[0] = '0;
        step();
        ls[0] = 1'b0;
        nrd = 0;
        for (int c = 0; c < 60 && inst[0].busy; c++) begin
            if (inst[0].bus.Read) begin
                if (nrd < 4) check("line4 read addr", 32'(inst[0].bus.Address), 32'(32'h100 + nrd));
                nrd++;
            end
            step();
        end
        check("line4 busy end", 32'(inst[0].busy), 32'(0));
        check("line4 reads", 32'(nrd), 32'(4));
        for (int k = 0; k < 4; k++) begin
            check("line4 valid", 32'(inst[0].pvalid), 32'(1));
            check("line4 byte", 32'(inst[0].pdata), 32'(k));
            pop[0] = 1'b1;
            step();
            pop[0] = 1'b0;
        end
        check("line4 drained", 32'(inst[0].pvalid), 32'(0));

        // Pop on empty FIFO.
        hold = inst[0].pdata;
        pop[0] = 1'b1;
        step();
        pop[0] = 1'b0;
        check("uflow set", 32'(inst[0].uflow), 32'(1));
        check("uflow pdata hold", 32'(inst[0].pdata), 32'(hold));

        // New line clears Underflow; abort it during the third byte's wait.
        ls[0] = 1'b1; lbase[0] = 18'h00200;
        step();
        ls[0] = 1'b0;
        check("uflow cleared", 32'(inst[0].uflow), 32'(0));
        nrd = 0;
        for (int c = 0; c < 60 && nrd < 3; c++) begin
            if (inst[0].bus.Read) nrd++;
            step();
        end
        check("abort 3rd read seen", 32'(nrd), 32'(3));
        ls[0] = 1'b1; lbase[0] = 18'h003A0;
        step();
        ls[0] = 1'b0;
        check("abort fifo empty", 32'(inst[0].pvalid), 32'(0));
        check("abort new addr", 32'(inst[0].bus.Address), 32'(18'h003A0));
        check("abort reissue", 32'(inst[0].bus.Read), 32'(1));
        for (int c = 0; c < 60 && inst[0].busy; c++) step();
        check("abort busy end", 32'(inst[0].busy), 32'(0));
        for (int k = 0; k < 4; k++) begin
            check("abort byte", 32'(inst[0].pdata), 32'(8'hA0 + 8'(k)));
            pop[0] = 1'b1;
            step();
            pop[0] = 1'b0;
        end
        check("abort drained", 32'(inst[0].pvalid), 32'(0));

        // Twenty-byte line with no pops: stalls after 16 reads.
        ls[1] = 1'b1; lbase[1] = 18'h00040; lpage[1] = '0;
        step();
        ls[1] = 1'b0;
        nrd = 0;
        repeat (80) begin
            if (inst[1].bus.Read) nrd++;
            step();
        end
        check("full reads", 32'(nrd), 32'(16));
        check("full read low", 32'(inst[1].bus.Read), 32'(0));
        check("full busy", 32'(inst[1].busy), 32'(1));
        check("full first byte", 32'(inst[1].pdata), 32'(8'h40 ^ key[1]));
        pop[1] = 1'b1;
        step();
        pop[1] = 1'b0;
        nrd = 0;
        repeat (10) begin
            if (inst[1].bus.Read) nrd++;
            step();
        end
        check("17th read", 32'(nrd), 32'(1));
        got = 0;
        for (int c = 0; c < 400 && got < 19; c++) begin
            if (inst[1].pvalid) begin
                check("full drain byte", 32'(inst[1].pdata), 32'(8'(32'h41 + got) ^ key[1]));
                got++;
                pop[1] = 1'b1;
            end else begin
                pop[1] = 1'b0;
            end
            step();
        end
        pop[1] = 1'b0;
        check("full drain count", 32'(got), 32'(19));
        check("full busy end", 32'(inst[1].busy), 32'(0));

        // Page carry: {0,0x3FFFF} then {1,0x00000}.
        ls[2] = 1'b1; lbase[2] = 18'h3FFFF; lpage[2] = 1'b0;
        step();
        ls[2] = 1'b0;
        nrd = 0;
        for (int c = 0; c < 30 && inst[2].busy; c++) begin
            if (inst[2].bus.Read) begin
                check("wrap read addr", 32'({inst[2].bus.PageMux, inst[2].bus.Address}),
                      (nrd == 0) ? 32'h0003FFFF : 32'h00040000);
                nrd++;
            end
            step();
        end
        check("wrap reads", 32'(nrd), 32'(2));

        // Reset while a read strobe is high and the FIFO holds data.
        ls[1] = 1'b1; lbase[1] = 18'h01000;
        step();
        ls[1] = 1'b0;
        for (int c = 0; c < 100 && !(inst[1].pvalid && inst[1].bus.Read); c++) step();
        check("reset precondition", 32'(inst[1].pvalid && inst[1].bus.Read), 32'(1));
        rst = 1'b1;
        #1;
        check("async rst read",   32'(inst[1].bus.Read), 32'(0));
        check("async rst busy",   32'(inst[1].busy),     32'(0));
        check("async rst pvalid", 32'(inst[1].pvalid),   32'(0));
        step();
        rst = 1'b0;
        step();

        // Random traffic on all instances.
        for (int n = 0; n < 3000; n++) begin
            popprob = (n < 1000) ? 15 : (n < 2000) ? 70 : 40;
            for (int i = 0; i < NI; i++) begin
                ls[i] = ($urandom_range(0, 70) == 0);
                if (ls[i]) begin
                    lbase[i] = A'($urandom);
                    lpage[i] = P'($urandom);
                    if ($urandom_range(0, 3) == 0) lbase[i] = 18'h3FFFF - 18'($urandom_range(0, 3));
                end
                pop[i] = !ls[i] && ($urandom_range(0, 99) < popprob);
            end
            step();
        end
        for (int i = 0; i < NI; i++) begin
            ls[i] = 1'b0; pop[i] = 1'b0;
        end
        repeat (4) step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
